// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction stream encoder:
// instruction classes, opcodes, FSM states and an immediate range helper.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    CLS_LOAD  = 4'd0,
    CLS_STORE = 4'd1,
    CLS_RTYPE = 4'd2,
    CLS_BTYPE = 4'd3,
    CLS_ITYPE = 4'd4,
    CLS_JAL   = 4'd5,
    CLS_JALR  = 4'd6,
    CLS_LUI   = 4'd7,
    CLS_AUIPC = 4'd8,
    CLS_NOP   = 4'd9
  } instr_class_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DRAIN,
    ST_DONE,
    ST_FULL
  } enc_state_e;

  // True when v is representable as a two's-complement number of 'bits' bits:
  // everything from the sign bit upward must be all zeros or all ones.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction class plus register/immediate fields
// to a 32-bit RV32I word, with an immediate range/alignment error flag.
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [3:0]  class_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_err_o
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    word_o      = '0;
    range_err_o = 1'b0;
    case (instr_class_e'(class_i))
      CLS_LOAD: begin
        word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        range_err_o = !fits_signed(imm_i, 12);
      end
      CLS_STORE: begin
        word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        range_err_o = !fits_signed(imm_i, 12);
      end
      CLS_RTYPE: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
      end
      CLS_BTYPE: begin
        word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], OP_BTYPE};
        range_err_o = !fits_signed(imm_i, 13) || imm_i[0];
      end
      CLS_ITYPE: begin
        word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ITYPE};
        range_err_o = !fits_signed(imm_i, 12);
      end
      CLS_JAL: begin
        word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        range_err_o = !fits_signed(imm_i, 21) || imm_i[0];
      end
      CLS_JALR: begin
        word_o      = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
        range_err_o = !fits_signed(imm_i, 12);
      end
      CLS_LUI: begin
        word_o = {imm_i[31:12], rd_i, OP_LUI};
      end
      CLS_AUIPC: begin
        word_o = {imm_i[31:12], rd_i, OP_AUIPC};
      end
      CLS_NOP: begin
        word_o = NOP_WORD;
      end
      default: begin
        word_o      = '0;
        range_err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams field-level instruction requests into instruction memory at
// consecutive word addresses, one registered write per accepted request.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(32'h0000_0FFC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_class,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  done,
  output logic                  err
);

  enc_state_e            state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [31:0] packed_word;
  logic        range_err;
  logic        accept;
  logic        write_done;
  logic        room_now;
  logic        room_next;

  instr_field_packer u_packer (
    .class_i     (in_class),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .funct3_i    (in_funct3),
    .funct7_i    (in_funct7),
    .imm_i       (in_imm),
    .word_o      (packed_word),
    .range_err_o (range_err)
  );

  // addr_q is where the pending (or next) word lands; a new request is only
  // taken if the word it produces still falls at or below ADDR_LIMIT.
  assign room_now   = (addr_q <= ADDR_LIMIT);
  assign room_next  = (addr_q <  ADDR_LIMIT);
  assign write_done = mem_we_q & mem_ready;
  assign in_ready   = (state_q == ST_ACCEPT) &
                      (mem_we_q ? (mem_ready & room_next) : room_now);
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    mem_we_d = mem_we_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wdata_d  = wdata_q;
    err_d    = err_q;

    if (write_done) begin
      mem_we_d = 1'b0;
      addr_d   = addr_q + ADDR_WIDTH'(4);
      count_d  = count_q + ADDR_WIDTH'(1);
    end

    if (accept) begin
      mem_we_d = 1'b1;
      wdata_d  = packed_word;
      if (range_err) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_FULL: begin
        if (start) begin
          state_d = ST_ACCEPT;
          addr_d  = {base_addr[ADDR_WIDTH-1:2], 2'b00};
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (accept && in_last) begin
          state_d = ST_DRAIN;
        end else if ((write_done && !room_next) || (!mem_we_q && !room_now)) begin
          state_d = ST_FULL;
          err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (write_done) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, and all state uses non-blocking assignments
  // so every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: single-word programs from a
// vector table plus hand-written multi-cycle sequences.
module tb_instr_stream_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_last;
  logic [31:0] base_addr, in_imm, mem_addr, mem_wdata, count;
  logic [3:0]  in_class;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        mem_we, mem_ready, done, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  instr_stream_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
    vec_t v;
    v = '{cls, rd, rs1, rs2, f3, f7, imm, 32'h0, 1'b0};
    return v;
  endfunction

  task automatic drive_req(input vec_t v, input logic last);
    in_class  = v.cls;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
    in_last   = last;
    in_valid  = 1'b1;
  endtask

  // Present a request, wait (bounded) for acceptance, return at posedge+1.
  task automatic push(input vec_t v, input logic last);
    drive_req(v, last);
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    check("push_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
    end
    check("done", done, 1);
  endtask

  task automatic do_start(input logic [31:0] addr);
    @(negedge clk);
    base_addr = addr;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
    in_funct7 = '0; in_imm = '0; mem_ready = 1'b1;

    //                cls        rd  rs1 rs2 f3  f7     imm            word           err
    vecs[0]  = '{CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3, 1'b0};
    vecs[1]  = '{CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0};
    vecs[2]  = '{CLS_JALR,  5'd1, 5'd5, 5'd9, 3'd7, 7'h00, 32'h0000_0004, 32'h0042_80E7, 1'b0};
    vecs[3]  = '{CLS_AUIPC, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_1517, 1'b0};
    vecs[4]  = '{CLS_NOP,   5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0};
    vecs[5]  = '{4'hF,      5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[6]  = '{CLS_ITYPE, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_8093, 1'b0};
    vecs[7]  = '{CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vecs[8]  = '{CLS_BTYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h8000_0063, 1'b1};
    vecs[9]  = '{CLS_JAL,   5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_00EF, 1'b1};
    vecs[10] = '{CLS_JAL,   5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0020_00EF, 1'b1};
    vecs[11] = '{CLS_STORE, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'hFE31_2FA3, 1'b0};
    vecs[12] = '{CLS_LOAD,  5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F7FF, 32'h7FF0_0003, 1'b1};
    vecs[13] = '{CLS_BTYPE, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0FFE, 32'h7E20_8FE3, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 0);

    // Single ITYPE program
    do_start(32'h100);
    push(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b1);
    check("p1_we", mem_we, 1);
    check("p1_addr", mem_addr, 32'h100);
    check("p1_wdata", mem_wdata, 32'h0050_0093);
    wait_done();
    check("p1_count", count, 1);

    // LOAD then STORE back to back
    do_start(32'h100);
    push(mk(CLS_LOAD, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8), 1'b0);
    check("p2_ld_addr", mem_addr, 32'h100);
    check("p2_ld_wdata", mem_wdata, 32'h0080_A103);
    push(mk(CLS_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12), 1'b1);
    check("p2_st_addr", mem_addr, 32'h104);
    check("p2_st_wdata", mem_wdata, 32'h0020_A623);
    wait_done();
    check("p2_count", count, 2);

    // BTYPE, JAL, LUI(last)
    do_start(32'h200);
    push(mk(CLS_BTYPE, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC), 1'b0);
    check("p3_b_addr", mem_addr, 32'h200);
    check("p3_b_wdata", mem_wdata, 32'hFE20_8EE3);
    push(mk(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8), 1'b0);
    check("p3_j_addr", mem_addr, 32'h204);
    check("p3_j_wdata", mem_wdata, 32'h0080_00EF);
    push(mk(CLS_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), 1'b1);
    check("p3_u_addr", mem_addr, 32'h208);
    check("p3_u_wdata", mem_wdata, 32'h1234_52B7);
    wait_done();
    check("p3_count", count, 3);
    check("p3_err", err, 0);

    // Memory stall for three cycles while a second request waits
    do_start(32'h300);
    mem_ready = 1'b0;
    push(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b0);
    drive_req(mk(CLS_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_we", mem_we, 1);
      check("stall_addr", mem_addr, 32'h300);
      check("stall_wdata", mem_wdata, 32'h0050_0093);
      check("stall_count", count, 0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stall_next_addr", mem_addr, 32'h304);
    check("stall_next_wdata", mem_wdata, 32'h0000_0013);
    check("stall_next_count", count, 1);
    wait_done();
    check("stall_count_end", count, 2);

    // Immediate errors are sticky until the next start
    do_start(32'h400);
    push(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 1'b0);
    check("e_i_wdata", mem_wdata, 32'h8000_0093);
    check("e_i_err", err, 1);
    push(mk(CLS_BTYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6), 1'b1);
    check("e_b_wdata", mem_wdata, 32'h0000_0363);
    check("e_b_err", err, 1);
    wait_done();
    check("e_done_err", err, 1);
    do_start(32'h500);
    check("e_restart_err", err, 0);
    check("e_restart_count", count, 0);
    check("e_restart_done", done, 0);
    push(mk(CLS_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b1);
    wait_done();

    // Table: one single-word program per vector
    for (int i = 0; i < 14; i++) begin
      do_start(32'h600 + 32'(i) * 32'h10);
      push(vecs[i], 1'b1);
      check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_word);
      check($sformatf("vec%0d_addr", i), mem_addr, 32'h600 + 32'(i) * 32'h10);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      wait_done();
      check($sformatf("vec%0d_count", i), count, 1);
    end

    // Running into ADDR_LIMIT without in_last
    do_start(32'hFF4);
    push(mk(CLS_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b0);
    push(mk(CLS_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b0);
    push(mk(CLS_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b0);
    check("full_last_addr", mem_addr, 32'hFFC);
    drive_req(mk(CLS_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b0);
    @(posedge clk); #1;
    check("full_err", err, 1);
    check("full_in_ready", in_ready, 0);
    check("full_we", mem_we, 0);
    check("full_count", count, 3);
    check("full_done", done, 0);
    @(posedge clk); #1;
    check("full_no_write", mem_we, 0);
    in_valid = 1'b0;
    do_start(32'h0);
    check("full_restart_err", err, 0);
    check("full_restart_count", count, 0);
    check("full_restart_ready", in_ready, 1);

    // Reset during a stalled write
    mem_ready = 1'b0;
    push(mk(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b0);
    check("rs_we_before", mem_we, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs_in_ready", in_ready, 0);
    check("rs_mem_we", mem_we, 0);
    check("rs_mem_addr", mem_addr, 0);
    check("rs_mem_wdata", mem_wdata, 0);
    check("rs_count", count, 0);
    check("rs_done", done, 0);
    check("rs_err", err, 0);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("rs_after_we", mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
